// File: rtl/rf_writeback_unit.sv
// Write-back stage: buffers one ALU and one load result, arbitrates them round-robin
// onto the single register-file write port, and tracks pending destinations for decode.
module rf_writeback_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 5
) (
    input  logic                    clk,
    input  logic                    rst_n,

    input  logic                    iss_valid,
    input  logic [DEPTH-1:0]        iss_rd,

    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [DEPTH-1:0]        alu_rd,
    input  logic [WIDTH-1:0]        alu_data,

    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [DEPTH-1:0]        mem_rd,
    input  logic [WIDTH-1:0]        mem_data,

    output logic                    wr,
    output logic [DEPTH-1:0]        write_register,
    output logic [WIDTH-1:0]        write_data,

    output logic [(2**DEPTH)-1:0]   busy,
    output logic                    idle
);

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_t;

    src_t                   last_grant;

    logic                   alu_full;
    logic [DEPTH-1:0]       alu_buf_rd;
    logic [WIDTH-1:0]       alu_buf_data;
    logic                   mem_full;
    logic [DEPTH-1:0]       mem_buf_rd;
    logic [WIDTH-1:0]       mem_buf_data;

    logic                   alu_grant;
    logic                   mem_grant;
    logic                   any_grant;
    logic                   alu_fire;
    logic                   mem_fire;
    logic [DEPTH-1:0]       win_rd;
    logic [WIDTH-1:0]       win_data;
    logic                   win_nonzero;
    logic [(2**DEPTH)-1:0]  busy_next;

    // On a tie the source that lost last time wins; a lone full buffer always wins.
    assign alu_grant = alu_full && (!mem_full || last_grant == SRC_MEM);
    assign mem_grant = mem_full && (!alu_full || last_grant == SRC_ALU);
    assign any_grant = alu_grant || mem_grant;

    // Readiness comes from registered state only, so no combinational path from valid.
    assign alu_ready = !alu_full || alu_grant;
    assign mem_ready = !mem_full || mem_grant;
    assign alu_fire  = alu_valid && alu_ready;
    assign mem_fire  = mem_valid && mem_ready;

    assign win_rd      = mem_grant ? mem_buf_rd   : alu_buf_rd;
    assign win_data    = mem_grant ? mem_buf_data : alu_buf_data;
    assign win_nonzero = (win_rd != '0);

    assign idle = !alu_full && !mem_full && !wr;

    // NOTE: every signal assigned in always_comb gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        busy_next = busy;
        if (any_grant && win_nonzero) begin
            busy_next[win_rd] = 1'b0;
        end
        // Applied after the clear so a same-edge reissue keeps the bit set.
        if (iss_valid && iss_rd != '0) begin
            busy_next[iss_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_full     <= 1'b0;
            alu_buf_rd   <= '0;
            alu_buf_data <= '0;
        end else if (alu_fire) begin
            alu_full     <= 1'b1;
            alu_buf_rd   <= alu_rd;
            alu_buf_data <= alu_data;
        end else if (alu_grant) begin
            alu_full     <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_full     <= 1'b0;
            mem_buf_rd   <= '0;
            mem_buf_data <= '0;
        end else if (mem_fire) begin
            mem_full     <= 1'b1;
            mem_buf_rd   <= mem_rd;
            mem_buf_data <= mem_data;
        end else if (mem_grant) begin
            mem_full     <= 1'b0;
        end
    end

    // Register-file port: index and data hold when idle; register 0 writes are dropped via wr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr             <= 1'b0;
            write_register <= '0;
            write_data     <= '0;
            last_grant     <= SRC_MEM;
        end else if (any_grant) begin
            wr             <= win_nonzero;
            write_register <= win_rd;
            write_data     <= win_data;
            last_grant     <= alu_grant ? SRC_ALU : SRC_MEM;
        end else begin
            wr             <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

endmodule

// File: tb/tb_rf_writeback_unit.sv
// Randomized scoreboard bench for rf_writeback_unit: a queue-based model predicts
// acceptances, write order and the busy bitmap; a monitor checks every write.
module tb_rf_writeback_unit;

    localparam int WIDTH = 32;
    localparam int DEPTH = 5;

    logic             clk;
    logic             rst_n;
    logic             iss_valid;
    logic [DEPTH-1:0] iss_rd;
    logic             alu_valid;
    logic             alu_ready;
    logic [DEPTH-1:0] alu_rd;
    logic [WIDTH-1:0] alu_data;
    logic             mem_valid;
    logic             mem_ready;
    logic [DEPTH-1:0] mem_rd;
    logic [WIDTH-1:0] mem_data;
    logic             wr;
    logic [DEPTH-1:0] write_register;
    logic [WIDTH-1:0] write_data;
    logic [31:0]      busy;
    logic             idle;

    rf_writeback_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .iss_valid      (iss_valid),
        .iss_rd         (iss_rd),
        .alu_valid      (alu_valid),
        .alu_ready      (alu_ready),
        .alu_rd         (alu_rd),
        .alu_data       (alu_data),
        .mem_valid      (mem_valid),
        .mem_ready      (mem_ready),
        .mem_rd         (mem_rd),
        .mem_data       (mem_data),
        .wr             (wr),
        .write_register (write_register),
        .write_data     (write_data),
        .busy           (busy),
        .idle           (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DEPTH-1:0] rd;
        logic [WIDTH-1:0] data;
    } entry_t;

    // Model state: accepted-but-unwritten results per source, expected writes in order.
    entry_t      alu_q[$];
    entry_t      mem_q[$];
    entry_t      sb_q[$];
    int          last_src;     // 0 = ALU won last, 1 = MEM won last
    logic [31:0] exp_busy;
    bit          exp_wr;

    int n_compared;
    int n_mismatched;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic reset_model();
        alu_q.delete();
        mem_q.delete();
        sb_q.delete();
        last_src = 1;
        exp_busy = '0;
        exp_wr   = 1'b0;
    endtask

    // One clock cycle: check outputs against the model, drive inputs, advance the model
    // to its post-edge state.
    task automatic step(input bit av, input logic [DEPTH-1:0] ard, input logic [WIDTH-1:0] ad,
                        input bit mv, input logic [DEPTH-1:0] mrd, input logic [WIDTH-1:0] md,
                        input bit iv, input logic [DEPTH-1:0] ird);
        int     g;
        bit     ea;
        bit     em;
        entry_t e;
        @(negedge clk);
        g = -1;
        if (alu_q.size() != 0 && mem_q.size() != 0) g = (last_src == 1) ? 0 : 1;
        else if (alu_q.size() != 0)                 g = 0;
        else if (mem_q.size() != 0)                 g = 1;
        ea = (alu_q.size() == 0) || (g == 0);
        em = (mem_q.size() == 0) || (g == 1);
        check("alu_ready", alu_ready, ea);
        check("mem_ready", mem_ready, em);
        check("busy", busy, exp_busy);
        check("idle", idle, (alu_q.size() == 0 && mem_q.size() == 0 && !exp_wr));

        alu_valid = av;  alu_rd = ard;  alu_data = ad;
        mem_valid = mv;  mem_rd = mrd;  mem_data = md;
        iss_valid = iv;  iss_rd = ird;

        exp_wr = 1'b0;
        if (g == 0) e = alu_q.pop_front();
        if (g == 1) e = mem_q.pop_front();
        if (g >= 0) begin
            last_src = g;
            if (e.rd != 0) begin
                sb_q.push_back(e);
                exp_wr = 1'b1;
                exp_busy[e.rd] = 1'b0;
            end
        end
        if (iv && ird != 0) exp_busy[ird] = 1'b1;
        if (av && ea) begin e.rd = ard; e.data = ad; alu_q.push_back(e); end
        if (mv && em) begin e.rd = mrd; e.data = md; mem_q.push_back(e); end
    endtask

    task automatic idle_step();
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    // Monitor: every asserted wr must match the oldest expected write.
    initial begin
        entry_t e;
        forever begin
            @(negedge clk);
            if (rst_n && wr) begin
                if (sb_q.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("FAIL unexpected_write: got reg %0d data %0h, required no write",
                             write_register, write_data);
                end else begin
                    e = sb_q.pop_front();
                    check("write_register", write_register, e.rd);
                    check("write_data", write_data, e.data);
                end
            end
        end
    end

    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        reset_model();
        rst_n     = 1'b0;
        iss_valid = 1'b0;  iss_rd = '0;
        alu_valid = 1'b0;  alu_rd = '0;  alu_data = '0;
        mem_valid = 1'b0;  mem_rd = '0;  mem_data = '0;

        #12;
        check("rst_wr", wr, 1'b0);
        check("rst_write_register", write_register, 0);
        check("rst_write_data", write_data, 0);
        check("rst_busy", busy, 0);
        check("rst_alu_ready", alu_ready, 1'b1);
        check("rst_mem_ready", mem_ready, 1'b1);
        check("rst_idle", idle, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) idle_step();

        // Issue rd=5, result arrives three cycles later.
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd5);
        idle_step();
        idle_step();
        step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, '0);
        repeat (3) idle_step();

        // Both sources streaming: alternation starting with ALU.
        repeat (12) step(1'b1, 5'd1, 32'h11111111, 1'b1, 5'd2, 32'h22222222, 1'b0, '0);
        repeat (4) idle_step();

        // ALU-only burst rd=1..8.
        for (int i = 1; i <= 8; i++)
            step(1'b1, DEPTH'(i), $urandom, 1'b0, '0, '0, 1'b0, '0);
        repeat (4) idle_step();

        // Load to register 0: accepted, never written, busy untouched.
        step(1'b0, '0, '0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, '0);
        repeat (3) idle_step();

        // Reissue of rd=7 on the edge that writes rd=7 keeps busy[7] set.
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
        step(1'b1, 5'd7, 32'h77777777, 1'b0, '0, '0, 1'b0, '0);
        step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7);
        repeat (3) idle_step();

        // Asynchronous reset while the ALU buffer is full and busy[9] is set.
        step(1'b1, 5'd9, 32'h99999999, 1'b0, '0, '0, 1'b1, 5'd9);
        @(posedge clk);
        #2;
        alu_valid = 1'b0;
        iss_valid = 1'b0;
        check("idle_before_reset", idle, 1'b0);
        check("busy_before_reset", busy, exp_busy);
        rst_n = 1'b0;
        #1;
        check("async_rst_idle", idle, 1'b1);
        check("async_rst_busy", busy, 0);
        check("async_rst_wr", wr, 1'b0);
        check("async_rst_alu_ready", alu_ready, 1'b1);
        check("async_rst_mem_ready", mem_ready, 1'b1);
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) idle_step();

        // Randomized traffic.
        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 3) != 0, DEPTH'($urandom), $urandom,
                 $urandom_range(0, 3) != 0, DEPTH'($urandom), $urandom,
                 $urandom_range(0, 1) != 0, DEPTH'($urandom));
        repeat (5) idle_step();
        check("scoreboard_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/rf_writeback_unit.md
# rf_writeback_unit

Write-back side of the multicycle datapath. Collects results from the ALU and memory-load paths through valid/ready handshakes, buffers one result per source, arbitrates round-robin onto the single register-file write port (`write_data` / `write_register` / `wr`), and keeps a pending-destination scoreboard that decode uses for hazard stalls. Writes to register 0 are accepted and discarded.

## Interface
- `WIDTH`, default 32: data width of each result.
- `DEPTH`, default 5: register index width; the file holds 2^DEPTH registers.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `iss_valid`  in  1  decode issues an instruction that will write `iss_rd`.
- `iss_rd`  in  DEPTH  destination of the issued instruction.
- `alu_valid`  in  1  ALU result available.
- `alu_ready`  out  1  ALU result accepted this cycle when high together with `alu_valid`.
- `alu_rd`  in  DEPTH  ALU destination register.
- `alu_data`  in  WIDTH  ALU result.
- `mem_valid`  in  1  load result available.
- `mem_ready`  out  1  load handshake ready.
- `mem_rd`  in  DEPTH  load destination register.
- `mem_data`  in  WIDTH  load data.
- `wr`  out  1  register-file write enable, registered.
- `write_register`  out  DEPTH  register-file write index, registered.
- `write_data`  out  WIDTH  register-file write data, registered.
- `busy`  out  2^DEPTH  pending-write bitmap; bit r set means register r has an outstanding result.
- `idle`  out  1  both buffers are empty and `wr` is 0.

## Operation
- Each source has a one-entry holding buffer with a full flag and the stored rd and data.
- A handshake fires when valid and ready are both high at the clock edge. The entry loads into that source's buffer.
- Readiness: `x_ready = !x_full || x_grant`. It depends only on registered state, never on any valid input.
- Arbitration runs each cycle over the full buffers:
  - Exactly one buffer full: that buffer is granted.
  - Both full: the source not granted last time wins.
  - The last-grant flag resets to MEM, so ALU wins the first tie.
- On a grant, at the clock edge:
  - The buffer clears, unless a new handshake on the same source reloads it in the same edge.
  - `write_register` and `write_data` take the granted entry.
  - `wr` is set to 1 if the entry's rd != 0, and to 0 otherwise.
- No grant at an edge: `wr` goes to 0. `write_register` and `write_data` hold their values.
- Scoreboard:
  - `iss_valid` with `iss_rd` != 0 sets `busy[iss_rd]`.
  - A grant with rd != 0 clears `busy[rd]` at the same edge that asserts `wr`.
  - Set and clear of the same index at the same edge: set wins, since a newer writer is outstanding.
  - `busy[0]` is constant 0.
- Results arriving with no matching busy bit are written normally. No error is flagged.
- The block does not reorder writes within a source.
- Across sources, ordering is arbitration order only. Decode must not issue two writers to the same rd in flight; `busy` exists to enforce this.

## Timing
- Reset (`rst_n` low, asynchronous) forces:
  - `wr`=0, `write_register`=0, `write_data`=0.
  - `busy`=0.
  - Both buffers empty, so `alu_ready`=`mem_ready`=1 and `idle`=1.
  - Last grant = MEM.
- Reset asserted mid-operation discards buffered entries and busy bits immediately, with no write emitted.
- Latency:
  - Handshake at edge N.
  - Entry granted during cycle N+1 with no contention.
  - `wr` high in the cycle after edge N+1.
  - Register file captures the value at edge N+2.
- A single source streams one result per cycle with ready held high.
- Both sources streaming: each gets every other grant. Each ready is high only in its granted cycles.
- Output port throughput is at most one write per cycle, with no idle gap between consecutive grants.

## Test plan
- Reset then idle → `wr`=0, both readys=1, `busy`=0, `idle`=1. Asserting `rst_n`=0 while a buffer is full → buffer empty and `busy` cleared without waiting for a clock edge.
- Issue rd=5, then 3 cycles later ALU valid rd=5 data=0xDEADBEEF → `busy[5]`=1 until the grant edge. `wr`=1, `write_register`=5, `write_data`=0xDEADBEEF exactly 1 cycle after the handshake edge, then `busy[5]`=0.
- ALU and MEM valid every cycle, ALU rd=1 data=0x11.., MEM rd=2 data=0x22.. → writes alternate 1,2,1,2,… with ALU first. Each ready toggles. No write is lost or duplicated.
- ALU-only burst of 8 results with rd=1..8 → 8 consecutive `wr` cycles in order, `alu_ready` constantly 1.
- MEM result with rd=0 data=0xFFFFFFFF → handshake accepted, `wr` stays 0, `busy` unchanged.
- At the edge granting rd=7, `iss_valid` with `iss_rd`=7 → `wr`=1 for register 7 and `busy[7]` remains 1 afterward.
